instr_fetch_queue: RTL and testbench

// - Instruction-fetch front end that sits directly upstream of the IF/ID staging register of the 32-bit pipelined core.
// - Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
// - Buffers returned words with their PC+4 in a small FIFO and presents them to decode with valid/ready.
// - Takes branch/jump redirects and discards wrong-path words, including responses still in flight.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifq_fifo.sv | 58 +++++
 rtl/instr_fetch_queue.sv | 119 +++++++++++
 tb/tb_instr_fetch_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: PC/instruction words,
// the buffered fetch entry and the fetch FSM state encoding.
package cpu_pkg;

   localparam int IFQ_ADDR_W = 7;
   localparam int PC_STEP    = 4;

   typedef logic [IFQ_ADDR_W-1:0] pc_t;
   typedef logic [31:0]           instr_t;

   typedef struct packed {
      instr_t instr;
      pc_t    pc_inc;
   } ifq_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched words with push/pop/clear.
// Clear wins over push and pop in the same cycle.
module ifq_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  ifq_entry_t       wdata,
   input  logic             pop,
   input  logic             clear,
   output ifq_entry_t       rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   ifq_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a full buffer still accepts a push when a pop frees the slot
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~clear)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns fetch PC, talks req/gnt/rvalid to imem, buffers words.
// Optional IFQ_BYPASS_EN forwards a returning word straight to decode.
module instr_fetch_queue
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = IFQ_ADDR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc_inc,
   input  logic              if_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    in_use;
   logic              full;
   logic              empty;
   logic              outstanding;
   logic              granted;
   logic              accept;
   logic              owed;
   logic              byp;
   logic              push;
   logic              pop;
   ifq_entry_t        head;
   ifq_entry_t        wentry;

   assign outstanding = (state == WAIT) | (state == DRAIN);
   assign in_use      = {1'b0, count} + (CNT_W+1)'(outstanding);
   assign imem_req    = (state == REQ) & (in_use < (CNT_W+1)'(DEPTH));
   assign imem_addr   = fetch_pc;
   assign granted     = imem_req & imem_gnt;
   assign accept      = (state == WAIT) & imem_rvalid;
   // a response is still owed after this cycle
   assign owed        = (outstanding & ~imem_rvalid) | granted;

`ifdef IFQ_BYPASS_EN
   assign byp = empty & accept & ~redirect_valid;
`else
   assign byp = 1'b0;
`endif

   assign push = accept & ~redirect_valid & ~(byp & if_ready)
               & (~full | pop);
   assign pop  = ~empty & if_ready & ~redirect_valid;

   // fetch_pc already points past the granted word
   assign wentry.instr  = imem_rdata;
   assign wentry.pc_inc = pc_t'(fetch_pc);

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .clear (redirect_valid),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      if_valid  = ~empty;
      if_instr  = empty ? '0 : head.instr;
      if_pc_inc = empty ? '0 : ADDR_W'(head.pc_inc);
      if (byp) begin
         if_valid  = 1'b1;
         if_instr  = imem_rdata;
         if_pc_inc = fetch_pc;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = REQ;
         REQ:     if (granted) state_nxt = WAIT;
         WAIT:    if (imem_rvalid) state_nxt = REQ;
         DRAIN:   if (imem_rvalid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid)
         state_nxt = owed ? DRAIN : REQ;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (redirect_valid)
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
         else if (granted)
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: memory responder plus an
// in-order stream model of the PCs/words decode must see.
module tb_instr_fetch_queue;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [6:0]  imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [6:0]  redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [6:0]  if_pc_inc;
   logic        if_ready;

   instr_fetch_queue dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc_inc      (if_pc_inc),
      .if_ready       (if_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [6:0] addr;
   } pend_t;

   logic [31:0] mem_words [32];
   pend_t       pend [$];
   logic [6:0]  gnt_q [$];
   int          pop_cyc [$];

   int          checks;
   int          failures;
   int          cyc;
   int          n_gnt;
   int          n_pop;
   int          lat_min;
   int          lat_max;
   logic        gnt_en;
   logic        rdy;
   logic        redir;
   logic        force_rv;
   logic [6:0]  rpc;
   logic [6:0]  exp_req;
   logic [6:0]  exp_inc;
   logic [6:0]  last_gnt_addr;
   logic [6:0]  last_pop_inc;
   logic        popped;

   // one clock: drive at negedge, check, then commit the model at posedge
   task automatic step();
      logic       rv;
      logic [6:0] a;
      rv = force_rv || (pend.size() > 0 && pend[0].due <= cyc);
      imem_rvalid    = rv;
      imem_rdata     = force_rv ? $urandom :
                       (pend.size() > 0 ? mem_words[pend[0].addr[6:2]] : 32'h0);
      imem_gnt       = gnt_en;
      if_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
      popped = 1'b0;
      if (imem_req && imem_gnt) begin
         checks++;
         if (imem_addr !== exp_req) begin
            failures++;
            $display("FAIL req_addr got=%h exp=%h cyc=%0d", imem_addr, exp_req, cyc);
         end
         last_gnt_addr = imem_addr;
         gnt_q.push_back(imem_addr);
         n_gnt++;
         pend.push_back('{cyc + $urandom_range(lat_max, lat_min), imem_addr});
         exp_req = exp_req + 7'd4;
      end
      if (if_valid && if_ready && !redir) begin
         a = exp_inc - 7'd4;
         checks++;
         if (if_pc_inc !== exp_inc || if_instr !== mem_words[a[6:2]]) begin
            failures++;
            $display("FAIL pop_word got=%h/%h exp=%h/%h cyc=%0d",
                     if_pc_inc, if_instr, exp_inc, mem_words[a[6:2]], cyc);
         end
         last_pop_inc = if_pc_inc;
         pop_cyc.push_back(cyc);
         exp_inc = exp_inc + 7'd4;
         n_pop++;
         popped = 1'b1;
      end
      if (redir) begin
         exp_req = {rpc[6:2], 2'b00};
         exp_inc = {rpc[6:2], 2'b00} + 7'd4;
      end
      @(posedge clk);
      if (rv && !force_rv)
         void'(pend.pop_front());
      cyc++;
      @(negedge clk);
   endtask

   task automatic model_clear();
      pend.delete();
      gnt_q.delete();
      pop_cyc.delete();
      exp_req = 7'd0;
      exp_inc = 7'd4;
      n_gnt   = 0;
      n_pop   = 0;
      cyc     = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b0;
      gnt_en         = 1'b0;
      rdy            = 1'b0;
      redir          = 1'b0;
      force_rv       = 1'b0;
      rpc            = 7'd0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 7'd0;
      if_ready       = 1'b0;
      repeat (2) @(negedge clk);
      model_clear();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 7'd0 || if_valid !== 1'b0 ||
          if_instr !== 32'h0 || if_pc_inc !== 7'd0) begin
         failures++;
         $display("FAIL reset_state got req=%b addr=%h v=%b i=%h p=%h exp 0",
                  imem_req, imem_addr, if_valid, if_instr, if_pc_inc);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_stream();
      do_reset();
      gnt_en = 1'b1; rdy = 1'b1; lat_min = 1; lat_max = 1;
      repeat (24) step();
      checks++;
      if (gnt_q.size() == 0 || gnt_q[0] !== 7'd0) begin
         failures++;
         $display("FAIL first_addr got=%h exp=00", gnt_q.size() ? gnt_q[0] : 7'h7f);
      end
      checks++;
      if (pop_cyc.size() < 8) begin
         failures++;
         $display("FAIL stream_count got=%0d exp>=8", pop_cyc.size());
      end
      for (int i = 1; i < pop_cyc.size(); i++) begin
         checks++;
         if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
            failures++;
            $display("FAIL stream_spacing got=%0d exp=2 idx=%0d",
                     pop_cyc[i] - pop_cyc[i-1], i);
         end
      end
   endtask

   task automatic test_backpressure();
      int k;
      do_reset();
      gnt_en = 1'b1; rdy = 1'b0; lat_min = 1; lat_max = 1;
      repeat (20) step();
      checks++;
      if (n_gnt != 4 || imem_req !== 1'b0) begin
         failures++;
         $display("FAIL bp_fill got gnts=%0d req=%b exp gnts=4 req=0", n_gnt, imem_req);
      end
      gnt_en = 1'b0; rdy = 1'b1;
      k = 0;
      while (k < 12) begin
         step();
         k++;
      end
      checks++;
      if (n_pop != 4 || last_pop_inc !== 7'd16) begin
         failures++;
         $display("FAIL bp_drain got pops=%0d last=%h exp pops=4 last=10", n_pop, last_pop_inc);
      end
   endtask

   task automatic test_redirect_inflight();
      int k;
      do_reset();
      gnt_en = 1'b1; rdy = 1'b1; lat_min = 3; lat_max = 3;
      k = 0;
      while (!(n_gnt == 3 && last_gnt_addr == 7'h08) && k < 30) begin
         step();
         k++;
      end
      checks++;
      if (k >= 30) begin
         failures++;
         $display("FAIL ri_timeout got gnts=%0d exp gnt at 08", n_gnt);
      end
      redir = 1'b1; rpc = 7'h40;
      step();
      redir = 1'b0;
      k = 0;
      popped = 1'b0;
      while (!popped && k < 40) begin
         step();
         k++;
      end
      checks++;
      if (!popped || last_pop_inc !== 7'h44) begin
         failures++;
         $display("FAIL ri_next got=%h exp=44 popped=%b", last_pop_inc, popped);
      end
   endtask

   task automatic test_redirect_rvalid();
      int k;
      do_reset();
      gnt_en = 1'b1; rdy = 1'b0; lat_min = 1; lat_max = 1;
      k = 0;
      while (n_gnt < 4 && k < 30) begin
         step();
         k++;
      end
      checks++;
      if (n_gnt != 4 || pend.size() != 1) begin
         failures++;
         $display("FAIL rr_setup got gnts=%0d pend=%0d exp 4/1", n_gnt, pend.size());
      end
      redir = 1'b1; rdy = 1'b1;
      rpc = 7'($urandom_range(4, 30) * 4);
      step();
      redir = 1'b0; rdy = 1'b0; gnt_en = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
         failures++;
         $display("FAIL rr_empty got if_valid=%b exp=0", if_valid);
      end
      gnt_en = 1'b1;
      k = n_gnt;
      repeat (6) step();
      checks++;
      if (n_gnt == k || gnt_q[k] !== rpc) begin
         failures++;
         $display("FAIL rr_restart got=%h exp=%h", n_gnt > k ? gnt_q[k] : 7'h7f, rpc);
      end
   endtask

   task automatic test_wrap();
      int k;
      do_reset();
      gnt_en = 1'b1; rdy = 1'b1; lat_min = 1; lat_max = 1;
      redir = 1'b1; rpc = 7'h7C;
      step();
      redir = 1'b0;
      gnt_q.delete();
      pop_cyc.delete();
      n_pop = 0;
      k = 0;
      while (n_pop < 2 && k < 30) begin
         step();
         k++;
      end
      checks++;
      if (gnt_q.size() < 2 || gnt_q[0] !== 7'h7C || gnt_q[1] !== 7'h00) begin
         failures++;
         $display("FAIL wrap_addr got=%h,%h exp=7c,00",
                  gnt_q.size() > 0 ? gnt_q[0] : 7'h7f, gnt_q.size() > 1 ? gnt_q[1] : 7'h7f);
      end
      checks++;
      if (n_pop < 2 || last_pop_inc !== 7'h04) begin
         failures++;
         $display("FAIL wrap_inc got pops=%0d last=%h exp 2/04", n_pop, last_pop_inc);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      gnt_en = 1'b1; rdy = 1'b1; lat_min = 3; lat_max = 3;
      k = 0;
      while (n_gnt < 1 && k < 10) begin
         step();
         k++;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 7'd0 || if_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_async got req=%b addr=%h v=%b exp 0/00/0",
                  imem_req, imem_addr, if_valid);
      end
      @(negedge clk);
      model_clear();
      reset = 1'b1;
      gnt_en = 1'b0; force_rv = 1'b1;
      repeat (2) step();
      force_rv = 1'b0;
      checks++;
      if (if_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_late got if_valid=%b exp=0", if_valid);
      end
      gnt_en = 1'b1;
      k = 0;
      popped = 1'b0;
      while (!popped && k < 20) begin
         step();
         k++;
      end
      checks++;
      if (!popped || last_pop_inc !== 7'd4) begin
         failures++;
         $display("FAIL midrst_first got=%h exp=04 popped=%b", last_pop_inc, popped);
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 3;
      repeat (800) begin
         gnt_en = ($urandom_range(0, 3) != 0);
         rdy    = ($urandom_range(0, 2) != 0);
         redir  = ($urandom_range(0, 24) == 0);
         rpc    = 7'($urandom);
         step();
      end
      redir = 1'b0;
      checks++;
      if (n_pop < 50) begin
         failures++;
         $display("FAIL rand_progress got=%0d exp>=50", n_pop);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      lat_min = 1;
      lat_max = 1;
      last_gnt_addr = 7'd0;
      last_pop_inc = 7'd0;
      for (int i = 0; i < 32; i++)
         mem_words[i] = $urandom;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
